fetch_delay_pipe: RTL and testbench

Parametrised replacement for the hand-chained fixed delay stages between IF and ID. It carries the fetched instruction, PC, PC+4 and branch-prediction bit through DEPTH register stages, each with its own valid bit. It adds per-stage valid tracking, bubble collapse under stall, backpressure to IF, and an occupancy count. One instance sits between IF (and the branch predictor) and ID.

---
 rtl/fetch_delay_pipe.sv | 107 ++++++++++
 tb/tb_fetch_delay_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_delay_pipe.sv
// IF->ID delay pipe: DEPTH valid-tracked register stages with bubble collapse,
// backpressure to IF, masked head outputs and a registered occupancy count.
module fetch_delay_pipe #(
   parameter int unsigned DEPTH  = 7,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              STALL,
   input  logic              Valid_IN,
   input  logic [DATA_W-1:0] Instr_IN,
   input  logic [DATA_W-1:0] Instr_PC_IN,
   input  logic [DATA_W-1:0] Instr_PC_Plus4_IN,
   input  logic              Branch_prediction_IN,
   output logic              Accept_OUT,
   output logic              Valid_OUT,
   output logic [DATA_W-1:0] Instr_OUT,
   output logic [DATA_W-1:0] Instr_PC_OUT,
   output logic [DATA_W-1:0] Instr_PC_Plus4_OUT,
   output logic              Branch_prediction_OUT,
   output logic [OCC_W-1:0]  Occupancy
);

   // Payload packing: {instr, pc, pc+4, bp}
   localparam int unsigned PW = 3 * DATA_W + 1;

   logic [DEPTH-1:0] v_q, v_d;
   logic [PW-1:0]    data_q [DEPTH];
   logic [DEPTH:0]   cap;
   logic [DEPTH-1:0] move;
   logic [DEPTH-1:0] load;
   logic             in_accept;
   logic             head_consume;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [PW-1:0]    head;

   // A stage can take a new entry if it is empty or its own entry can move on.
   always_comb begin
      cap        = '0;
      cap[DEPTH] = ~STALL;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         cap[k] = ~v_q[k] | cap[k+1];
      end
   end

   always_comb begin
      move         = v_q & cap[DEPTH:1];
      in_accept    = Valid_IN & cap[0];
      head_consume = move[DEPTH-1];
      load         = '0;
      load[0]      = in_accept;
      for (int k = 1; k < int'(DEPTH); k++) begin
         load[k] = move[k-1];
      end
   end

   always_comb begin
      v_d   = (v_q & ~move) | load;
      occ_d = occ_q + OCC_W'(in_accept) - OCC_W'(head_consume);
      if (FLUSH) begin
         v_d   = '0;
         occ_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         v_q   <= '0;
         occ_q <= '0;
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
      end
   end

   // Payload is only enabled by load; a flushed load is harmless since v is cleared.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            data_q[k] <= '0;
         end
      end else begin
         if (load[0]) begin
            data_q[0] <= {Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN, Branch_prediction_IN};
         end
         for (int k = 1; k < int'(DEPTH); k++) begin
            if (load[k]) begin
               data_q[k] <= data_q[k-1];
            end
         end
      end
   end

   always_comb begin
      Valid_OUT             = v_q[DEPTH-1];
      head                  = Valid_OUT ? data_q[DEPTH-1] : '0;
      Instr_OUT             = head[3*DATA_W -: DATA_W];
      Instr_PC_OUT          = head[2*DATA_W -: DATA_W];
      Instr_PC_Plus4_OUT    = head[DATA_W -: DATA_W];
      Branch_prediction_OUT = head[0];
      Accept_OUT            = cap[0];
      Occupancy             = occ_q;
   end

endmodule

// File: tb/tb_fetch_delay_pipe.sv
// Directed bench for fetch_delay_pipe: DEPTH=7 main instance plus a DEPTH=1 instance.
module tb_fetch_delay_pipe;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RESET;

   // DEPTH=7 instance signals
   logic        flush, stall, vin, bp;
   logic [31:0] instr, pc, pc4;
   logic        acc, vout, bp_out;
   logic [31:0] instr_out, pc_out, pc4_out;
   logic [2:0]  occ;

   // DEPTH=1 instance signals
   logic        flush1, stall1, vin1, bp1;
   logic [31:0] instr1, pc1, pc41;
   logic        acc1, vout1, bp_out1;
   logic [31:0] instr_out1, pc_out1, pc4_out1;
   logic [0:0]  occ1;

   int tests = 0;
   int fails = 0;

   fetch_delay_pipe #(.DEPTH(7), .DATA_W(32)) dut7 (
      .CLK(CLK), .RESET(RESET), .FLUSH(flush), .STALL(stall), .Valid_IN(vin),
      .Instr_IN(instr), .Instr_PC_IN(pc), .Instr_PC_Plus4_IN(pc4),
      .Branch_prediction_IN(bp), .Accept_OUT(acc), .Valid_OUT(vout),
      .Instr_OUT(instr_out), .Instr_PC_OUT(pc_out), .Instr_PC_Plus4_OUT(pc4_out),
      .Branch_prediction_OUT(bp_out), .Occupancy(occ)
   );

   fetch_delay_pipe #(.DEPTH(1), .DATA_W(32)) dut1 (
      .CLK(CLK), .RESET(RESET), .FLUSH(flush1), .STALL(stall1), .Valid_IN(vin1),
      .Instr_IN(instr1), .Instr_PC_IN(pc1), .Instr_PC_Plus4_IN(pc41),
      .Branch_prediction_IN(bp1), .Accept_OUT(acc1), .Valid_OUT(vout1),
      .Instr_OUT(instr_out1), .Instr_PC_OUT(pc_out1), .Instr_PC_Plus4_OUT(pc4_out1),
      .Branch_prediction_OUT(bp_out1), .Occupancy(occ1)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic b);
      vin   = v;
      instr = i;
      pc    = p;
      pc4   = (v) ? p + 32'd4 : 32'd0;
      bp    = b;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if (vout !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %b want 0", vout);
      end
      tests++;
      if (occ !== 3'd0) begin
         fails++; $display("FAIL reset_occ: got %0d want 0", occ);
      end
      tests++;
      if (acc !== 1'b1) begin
         fails++; $display("FAIL reset_accept: got %b want 1", acc);
      end
      tests++;
      if (instr_out !== 32'd0 || pc_out !== 32'd0 || pc4_out !== 32'd0 || bp_out !== 1'b0) begin
         fails++; $display("FAIL reset_outputs: got %h/%h/%h/%b want zeros",
                           instr_out, pc_out, pc4_out, bp_out);
      end
      @(posedge CLK);
      #1 RESET = 1'b1;
   endtask

   task automatic test_latency();
      set_in(1'b1, 32'h2402000A, 32'h00400000, 1'b1);
      #1;
      tests++;
      if (acc !== 1'b1) begin
         fails++; $display("FAIL lat_accept: got %b want 1", acc);
      end
      step();
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (vout !== 1'b0) begin
            fails++; $display("FAIL lat_early_valid[%0d]: got %b want 0", i, vout);
         end
         step();
      end
      tests++;
      if (vout !== 1'b1 || instr_out !== 32'h2402000A || pc_out !== 32'h00400000 ||
          pc4_out !== 32'h00400004 || bp_out !== 1'b1) begin
         fails++; $display("FAIL lat_head: got v=%b %h/%h/%h/%b want 1 2402000a/00400000/00400004/1",
                           vout, instr_out, pc_out, pc4_out, bp_out);
      end
      tests++;
      if (occ !== 3'd1) begin
         fails++; $display("FAIL lat_occ: got %0d want 1", occ);
      end
      step();
      tests++;
      if (vout !== 1'b0 || instr_out !== 32'd0 || occ !== 3'd0) begin
         fails++; $display("FAIL lat_after: got v=%b instr=%h occ=%0d want 0 0 0",
                           vout, instr_out, occ);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0);
         step();
      end
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (vout !== 1'b1 || instr_out !== 32'h100 || occ !== 3'd3) begin
         fails++; $display("FAIL arst_pre: got v=%b instr=%h occ=%0d want 1 100 3",
                           vout, instr_out, occ);
      end
      #2 RESET = 1'b0;
      #1;
      tests++;
      if (vout !== 1'b0 || occ !== 3'd0 || acc !== 1'b1 || instr_out !== 32'd0) begin
         fails++; $display("FAIL arst_now: got v=%b occ=%0d acc=%b instr=%h want 0 0 1 0",
                           vout, occ, acc, instr_out);
      end
      stall = 1'b0;
      @(posedge CLK);
      #1 RESET = 1'b1;
   endtask

   task automatic test_bubble_and_full_release();
      logic [31:0] exp_q [7];
      int occ_m;
      logic exp_acc;
      stall = 1'b1;
      set_in(1'b1, 32'hA0000001, 32'h1000, 1'b0);
      step();
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      step();
      set_in(1'b1, 32'hB0000002, 32'h1004, 1'b1);
      step();
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) step();
      tests++;
      if (vout !== 1'b1 || instr_out !== 32'hA0000001 || occ !== 3'd2) begin
         fails++; $display("FAIL bubble_head: got v=%b instr=%h occ=%0d want 1 a0000001 2",
                           vout, instr_out, occ);
      end
      occ_m = 2;
      for (int i = 0; i < 6; i++) begin
         set_in(1'b1, 32'hC0000000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0);
         #1;
         exp_acc = (occ_m < 7);
         tests++;
         if (acc !== exp_acc) begin
            fails++; $display("FAIL fill_accept[%0d]: got %b want %b", i, acc, exp_acc);
         end
         step();
         if (exp_acc) occ_m++;
      end
      tests++;
      if (occ !== 3'd7) begin
         fails++; $display("FAIL fill_occ: got %0d want 7", occ);
      end
      // Full and stalled: X must be refused.
      set_in(1'b1, 32'hDEAD0001, 32'h4000, 1'b1);
      #1;
      tests++;
      if (acc !== 1'b0) begin
         fails++; $display("FAIL full_stall_accept: got %b want 0", acc);
      end
      step();
      tests++;
      if (occ !== 3'd7 || instr_out !== 32'hA0000001) begin
         fails++; $display("FAIL full_stall_hold: got occ=%0d instr=%h want 7 a0000001",
                           occ, instr_out);
      end
      stall = 1'b0;
      #1;
      tests++;
      if (acc !== 1'b1) begin
         fails++; $display("FAIL release_accept: got %b want 1", acc);
      end
      step();
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      tests++;
      if (occ !== 3'd7) begin
         fails++; $display("FAIL release_occ: got %0d want 7", occ);
      end
      exp_q[0] = 32'hB0000002;
      for (int i = 0; i < 5; i++) exp_q[i+1] = 32'hC0000000 + 32'(i);
      exp_q[6] = 32'hDEAD0001;
      for (int j = 0; j < 7; j++) begin
         tests++;
         if (vout !== 1'b1 || instr_out !== exp_q[j]) begin
            fails++; $display("FAIL drain[%0d]: got v=%b instr=%h want 1 %h",
                              j, vout, instr_out, exp_q[j]);
         end
         step();
      end
      tests++;
      if (vout !== 1'b0 || occ !== 3'd0) begin
         fails++; $display("FAIL drain_empty: got v=%b occ=%0d want 0 0", vout, occ);
      end
   endtask

   task automatic test_flush();
      stall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_in(1'b1, 32'hF0000000 + 32'(i), 32'h5000 + 32'(4 * i), 1'b1);
         step();
      end
      tests++;
      if (occ !== 3'd7) begin
         fails++; $display("FAIL flush_prefill: got occ=%0d want 7", occ);
      end
      set_in(1'b1, 32'hDDDD0000, 32'h6000, 1'b1);
      flush = 1'b1;
      stall = 1'b0;
      #1;
      tests++;
      if (vout !== 1'b1 || instr_out !== 32'hF0000000 || acc !== 1'b1) begin
         fails++; $display("FAIL flush_cycle: got v=%b instr=%h acc=%b want 1 f0000000 1",
                           vout, instr_out, acc);
      end
      step();
      flush = 1'b0;
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      tests++;
      if (vout !== 1'b0 || instr_out !== 32'd0 || pc_out !== 32'd0 || pc4_out !== 32'd0 ||
          bp_out !== 1'b0 || occ !== 3'd0) begin
         fails++; $display("FAIL flush_after: got v=%b %h/%h/%h/%b occ=%0d want all 0",
                           vout, instr_out, pc_out, pc4_out, bp_out, occ);
      end
      set_in(1'b1, 32'hEEEE0001, 32'h7000, 1'b0);
      step();
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (vout !== 1'b0) begin
            fails++; $display("FAIL flush_ghost[%0d]: got v=%b instr=%h want 0", i, vout, instr_out);
         end
         step();
      end
      tests++;
      if (vout !== 1'b1 || instr_out !== 32'hEEEE0001 || pc_out !== 32'h7000) begin
         fails++; $display("FAIL flush_next: got v=%b instr=%h pc=%h want 1 eeee0001 7000",
                           vout, instr_out, pc_out);
      end
      step();
   endtask

   task automatic test_depth1();
      logic [31:0] q [$];
      logic [31:0] next_val;
      logic exp_acc;
      int popped;
      next_val = 32'd1;
      popped   = 0;
      for (int cyc = 0; cyc < 31; cyc++) begin
         stall1 = (cyc % 2 == 0) && (cyc < 30);
         vin1   = (cyc < 30);
         instr1 = next_val;
         pc1    = next_val << 2;
         pc41   = (next_val << 2) + 32'd4;
         bp1    = next_val[0];
         #1;
         tests++;
         if (vout1 !== (q.size() != 0) || occ1 !== 1'(q.size())) begin
            fails++; $display("FAIL d1_valid[%0d]: got v=%b occ=%0d want %0d", cyc, vout1, occ1,
                              q.size());
         end
         exp_acc = (q.size() == 0) || !stall1;
         tests++;
         if (acc1 !== exp_acc) begin
            fails++; $display("FAIL d1_accept[%0d]: got %b want %b", cyc, acc1, exp_acc);
         end
         if (q.size() != 0) begin
            tests++;
            if (instr_out1 !== q[0] || pc_out1 !== (q[0] << 2) || bp_out1 !== q[0][0]) begin
               fails++; $display("FAIL d1_data[%0d]: got %h/%h/%b want %h", cyc, instr_out1,
                                 pc_out1, bp_out1, q[0]);
            end
            if (!stall1) begin
               void'(q.pop_front());
               popped++;
            end
         end
         if (exp_acc && vin1) begin
            q.push_back(next_val);
            next_val++;
         end
         step();
      end
      tests++;
      if (popped != int'(next_val) - 1 || q.size() != 0) begin
         fails++; $display("FAIL d1_count: got popped=%0d want %0d", popped, next_val - 1);
      end
   endtask

   initial begin
      RESET  = 1'b0;
      flush  = 1'b0;
      stall  = 1'b0;
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      flush1 = 1'b0;
      stall1 = 1'b0;
      vin1   = 1'b0;
      instr1 = 32'd0;
      pc1    = 32'd0;
      pc41   = 32'd0;
      bp1    = 1'b0;
      test_reset();
      test_latency();
      test_async_reset();
      test_bubble_and_full_release();
      test_flush();
      test_depth1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
